fb_scanout_reader: RTL
======================

Name: fb_scanout_reader

Overview:
Reads a completed frame back out of the framebuffer that the rasterizer writes, in raster order (row 0 first, left to right). It produces a flow-controlled 24-bit RGB pixel stream with start-of-frame and end-of-line markers for the display or stream sink. It is the read-side counterpart of the rasterizer's framebuffer write port and uses the same linear addressing: addr = y*H_ACTIVE + x. A small FIFO holds prefetched pixels, and read issue is credit-limited so the FIFO can never overflow.

Parameters:
H_ACTIVE, 1920, pixels per line
V_ACTIVE, 1080, lines per frame
RD_LATENCY, 2, cycles from fb_rd_en asserted to fb_rd_data valid (fixed, >=1)
FIFO_DEPTH, 8, pixel FIFO entries (power of 2, >= RD_LATENCY+1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a frame scan when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  1-cycle pulse after the last pixel is accepted downstream
fb_rd_addr  out  21  framebuffer read address
fb_rd_en  out  1  read strobe, one pixel per cycle
fb_rd_data  in  24  read data, valid RD_LATENCY cycles after fb_rd_en
pix_data  out  24  RGB 8:8:8 pixel, FIFO head
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  sink accepts when pix_valid & pix_ready
pix_sof  out  1  head pixel is (x=0,y=0); qualified by pix_valid
pix_eol  out  1  head pixel is x=H_ACTIVE-1; qualified by pix_valid

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; busy, done, fb_rd_en, pix_valid, pix_sof, pix_eol = 0; fb_rd_addr=0; pix_data=0; counters, FIFO pointers and in-flight pipe cleared. Any in-flight read data is discarded.
- States: IDLE, ISSUE, DRAIN.
  - IDLE: on start, clear rd_x, rd_y and rd_addr, then go to ISSUE. start is ignored in any other state.
  - ISSUE: fb_rd_en=1 on a cycle only when credit exists: fifo_count + inflight + 1 <= FIFO_DEPTH, where inflight is the number of reads issued but not yet returned.
    - fb_rd_addr is driven combinationally from rd_addr.
    - On each issue: rd_addr+1. rd_x+1, wrapping to 0 at H_ACTIVE-1 with rd_y+1.
    - Addresses are generated incrementally (no multiplier). The address equals rd_y*H_ACTIVE + rd_x.
    - After issuing (x=H_ACTIVE-1, y=V_ACTIVE-1), go to DRAIN.
  - DRAIN: no reads. When inflight=0 and fifo_count=0, pulse done for 1 cycle, busy=0, and go to IDLE.
- Read return pipe: a RD_LATENCY-deep shift register carries {valid, sof, eol} alongside each read. When the pipe output is valid, push {fb_rd_data, sof, eol} into the FIFO. The credit rule guarantees the push never meets a full FIFO. A push into a full FIFO is a design error and the bench asserts on it.
- FIFO:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop occurs on pix_valid & pix_ready.
  - pix_data, pix_sof and pix_eol show the head entry and are stable while pix_valid=1 and pix_ready=0.
- Throughput: with pix_ready held high, one pixel per cycle is sustained. The first pix_valid appears RD_LATENCY+1 cycles after the first fb_rd_en (one cycle for the FIFO write).
- Backpressure: with pix_ready=0, issue stops once fifo_count+inflight reaches FIFO_DEPTH. Reads resume the cycle after the first pop frees a credit.
- Widths:
  - fifo_count is clog2(FIFO_DEPTH)+1 bits.
  - inflight is clog2(RD_LATENCY+1) bits.
  - rd_x and rd_y are 11 bits each.
  - The address is 21 bits. H_ACTIVE*V_ACTIVE must be <= 2^21; 1920*1080 fits.
- done and busy:
  - done never coincides with busy=1.
  - A start arriving on the same cycle as done is ignored, because state is not yet IDLE.
  - A start on the cycle after done is accepted.
- Reset asserted mid-frame returns the block to IDLE immediately. No done pulse is generated.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, RD_LATENCY=2, memory model returns data=addr. Pulse start with pix_ready=1 -> fb_rd_addr 0..7 on 8 consecutive cycles; pix_data 0..7 in order; pix_sof only on pixel 0; pix_eol on pixels 3 and 7; done pulses once; busy low afterwards.
- Same config, pix_ready=0 for 20 cycles after start -> exactly FIFO_DEPTH=8 reads issued, never more; pix_valid=1 with pix_data=0 held stable. Release pix_ready -> remaining pixels 0..7 in order, no loss or duplication.
- Random pix_ready (50%) over 1920x1080 with default parameters -> 2,073,600 pixels accepted in address order; last pixel has pix_eol=1; FIFO never overflows; done pulses exactly once.
- start pulsed while busy, and start pulsed in the same cycle as done -> both ignored (no address restart). start one cycle later -> a new frame begins at addr 0.
- Assert reset_n=0 mid-frame (after ~5 pixels), then release and pulse start -> outputs zero during reset; no done; the new frame starts at addr 0 with pix_sof on its first pixel; no stale pre-reset data appears.
- RD_LATENCY=4, FIFO_DEPTH=8, pix_ready=1 -> first pix_valid 5 cycles after the first fb_rd_en; one pixel per cycle sustained thereafter.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader: walks a frame in raster order, issues credit-limited
// reads and streams the returned pixels through a small FIFO with SOF/EOL markers.
module fb_scanout_reader #(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [20:0] fb_rd_addr,
  output logic        fb_rd_en,
  input  logic [23:0] fb_rd_data,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(RD_LATENCY + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [10:0]           r_rdX;
  logic [10:0]           r_rdY;
  logic [20:0]           r_rdAddr;
  logic [RD_LATENCY-1:0] r_pipeValid;
  logic [RD_LATENCY-1:0] r_pipeSof;
  logic [RD_LATENCY-1:0] r_pipeEol;
  logic [IW-1:0]         r_inflight;
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         r_wrPtr;
  logic [AW-1:0]         r_rdPtr;
  logic [23:0]           r_memData [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_memSof;
  logic [FIFO_DEPTH-1:0] r_memEol;

  logic w_credit;
  logic w_issue;
  logic w_lastX;
  logic w_lastY;
  logic w_push;
  logic w_pop;

  // A read may only go out if its data is guaranteed a FIFO slot on return.
  assign w_credit = (SW'(r_count) + SW'(r_inflight) + SW'(1)) <= SW'(FIFO_DEPTH);
  assign w_issue  = (r_state == ISSUE) && w_credit;
  assign w_lastX  = (r_rdX == 11'(H_ACTIVE - 1));
  assign w_lastY  = (r_rdY == 11'(V_ACTIVE - 1));
  assign w_push   = r_pipeValid[RD_LATENCY-1];
  assign w_pop    = pix_valid && pix_ready;

  assign fb_rd_en   = w_issue;
  assign fb_rd_addr = r_rdAddr;
  assign pix_valid  = (r_count != '0);
  assign pix_data   = pix_valid ? r_memData[r_rdPtr] : '0;
  assign pix_sof    = pix_valid && r_memSof[r_rdPtr];
  assign pix_eol    = pix_valid && r_memEol[r_rdPtr];

  always_comb begin
    w_nextState = r_state;
    done        = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_nextState = ISSUE;
      ISSUE: if (w_issue && w_lastX && w_lastY) w_nextState = DRAIN;
      DRAIN: begin
        if (r_inflight == '0 && r_count == '0) begin
          done        = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    // done is decoded while still in DRAIN, so busy is masked to keep them exclusive
    busy = (r_state != IDLE) && !done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_rdX       <= '0;
      r_rdY       <= '0;
      r_rdAddr    <= '0;
      r_pipeValid <= '0;
      r_pipeSof   <= '0;
      r_pipeEol   <= '0;
      r_inflight  <= '0;
      r_count     <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
    end else begin
      r_state <= w_nextState;

      if (r_state == IDLE && start) begin
        r_rdX    <= '0;
        r_rdY    <= '0;
        r_rdAddr <= '0;
      end else if (w_issue) begin
        r_rdAddr <= r_rdAddr + 21'd1;
        if (w_lastX) begin
          r_rdX <= '0;
          r_rdY <= r_rdY + 11'd1;
        end else begin
          r_rdX <= r_rdX + 11'd1;
        end
      end

      // Markers travel beside each read so they line up with the returned data.
      r_pipeValid[0] <= w_issue;
      r_pipeSof[0]   <= w_issue && (r_rdX == '0) && (r_rdY == '0);
      r_pipeEol[0]   <= w_issue && w_lastX;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeSof[i]   <= r_pipeSof[i-1];
        r_pipeEol[i]   <= r_pipeEol[i-1];
      end

      r_inflight <= r_inflight + IW'(w_issue) - IW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memData[r_wrPtr] <= fb_rd_data;
      r_memSof[r_wrPtr]  <= r_pipeSof[RD_LATENCY-1];
      r_memEol[r_wrPtr]  <= r_pipeEol[RD_LATENCY-1];
    end
  end

endmodule
